// File: rtl/sc_accum_sequencer.sv
// sc_accum_sequencer
// Runs one stochastic-computing accumulation over a programmed number of
// bitstream beats. Each run reseeds and enables the SNGs, sums the popcount of
// every accepted beat, and publishes the total over a valid/ready handshake.
module sc_accum_sequencer #(
    parameter int NUM_BITS = 8,
    parameter int LEN_W    = 16,
    parameter int ACC_W    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                abort,
    output logic                busy,
    output logic                sng_clear,
    output logic                sng_en,
    input  logic                bit_valid,
    input  logic [NUM_BITS-1:0] bit_in,
    output logic                bit_ready,
    output logic [ACC_W-1:0]    result,
    output logic                res_valid,
    input  logic                res_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] beat_ones;
    logic [ACC_W-1:0] acc_next;
    logic             beat_accepted;

    // Number of ones in the current beat, zero-extended to accumulator width.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first; otherwise a path that skips the assignment infers a latch.
        beat_ones = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            beat_ones = beat_ones + ACC_W'(bit_in[i]);
        end
    end

    // bit_ready is only ever high in RUN, so a handshake implies RUN.
    assign beat_accepted = bit_valid && bit_ready;
    assign acc_next      = acc + beat_ones;

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            result    <= '0;
            busy      <= 1'b0;
            sng_clear <= 1'b0;
            sng_en    <= 1'b0;
            bit_ready <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            // sng_clear is a single-cycle pulse; it is only set on RUN entry.
            sng_clear <= 1'b0;

            if (abort) begin
                // Abort wins over everything; the published result is kept.
                state     <= IDLE;
                busy      <= 1'b0;
                sng_en    <= 1'b0;
                bit_ready <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (len != '0) begin
                                state     <= RUN;
                                remaining <= len;
                                acc       <= '0;
                                sng_clear <= 1'b1;
                                sng_en    <= 1'b1;
                                bit_ready <= 1'b1;
                            end else begin
                                // Empty run: publish zero without touching SNGs.
                                state     <= DONE;
                                result    <= '0;
                                res_valid <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        if (beat_accepted) begin
                            acc       <= acc_next;
                            remaining <= remaining - LEN_W'(1);
                            if (remaining == LEN_W'(1)) begin
                                state     <= DONE;
                                result    <= acc_next;
                                res_valid <= 1'b1;
                                sng_en    <= 1'b0;
                                bit_ready <= 1'b0;
                            end
                        end
                    end

                    DONE: begin
                        if (res_ready) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            res_valid <= 1'b0;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sng_en    <= 1'b0;
                        bit_ready <= 1'b0;
                        res_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sc_accum_sequencer.sv
// Self-checking bench for sc_accum_sequencer: a transaction-level model
// (beats left, running sum, pending result) is compared against the DUT on
// every falling edge, alongside directed scenarios with literal expectations.
module tb_sc_accum_sequencer;

    localparam int NUM_BITS = 8;
    localparam int LEN_W    = 16;
    localparam int ACC_W    = 20;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [LEN_W-1:0]    len = '0;
    logic                abort = 1'b0;
    logic                busy;
    logic                sng_clear;
    logic                sng_en;
    logic                bit_valid = 1'b0;
    logic [NUM_BITS-1:0] bit_in = '0;
    logic                bit_ready;
    logic [ACC_W-1:0]    result;
    logic                res_valid;
    logic                res_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    sc_accum_sequencer #(
        .NUM_BITS(NUM_BITS),
        .LEN_W   (LEN_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .busy     (busy),
        .sng_clear(sng_clear),
        .sng_en   (sng_en),
        .bit_valid(bit_valid),
        .bit_in   (bit_in),
        .bit_ready(bit_ready),
        .result   (result),
        .res_valid(res_valid),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is "beats still owed" plus a running sum; a
    // finished run leaves a pending result until it is taken or aborted.
    int          m_left;
    int          m_sum;
    int          m_result;
    bit          m_pend;
    bit          m_first;

    // Model update: one step of the run bookkeeping per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_sum    <= 0;
            m_result <= 0;
            m_pend   <= 1'b0;
            m_first  <= 1'b0;
        end else begin
            m_first <= 1'b0;
            if (abort) begin
                m_left <= 0;
                m_pend <= 1'b0;
            end else if (m_pend) begin
                if (res_ready) m_pend <= 1'b0;
            end else if (m_left > 0) begin
                if (bit_valid) begin
                    m_sum  <= m_sum + $countones(bit_in);
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_pend   <= 1'b1;
                        m_result <= m_sum + $countones(bit_in);
                    end
                end
            end else if (start) begin
                if (len == 0) begin
                    m_pend   <= 1'b1;
                    m_result <= 0;
                end else begin
                    m_left  <= int'(len);
                    m_sum   <= 0;
                    m_first <= 1'b1;
                end
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp_busy",      32'(busy),      32'(m_left > 0 || m_pend));
            check("cmp_sng_clear", 32'(sng_clear), 32'(m_first));
            check("cmp_sng_en",    32'(sng_en),    32'(m_left > 0));
            check("cmp_bit_ready", 32'(bit_ready), 32'(m_left > 0));
            check("cmp_res_valid", 32'(res_valid), 32'(m_pend));
            check("cmp_result",    32'(result),    32'(m_result));
        end
    end

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!res_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) check("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    logic [7:0] stall_beats [3] = '{8'h01, 8'h03, 8'h07};
    int n;
    int en_cycles;

    initial begin
        // Reset with random inputs toggling.
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom); len = LEN_W'($urandom); abort = 1'($urandom);
            bit_valid = 1'($urandom); bit_in = NUM_BITS'($urandom); res_ready = 1'($urandom);
        end
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_sng_en", 32'(sng_en), 32'd0);
        start = 1'b0; len = '0; abort = 1'b0; bit_valid = 1'b0; bit_in = '0; res_ready = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_res_valid", 32'(res_valid), 32'd0);

        // Basic run: len=4, all ones, continuous valid.
        start = 1'b1; len = 16'd4; bit_valid = 1'b1; bit_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        check("basic_clear_first", 32'(sng_clear), 32'd1);
        en_cycles = 0; n = 0;
        while (!res_valid && n < 20) begin
            if (sng_en) en_cycles++;
            @(negedge clk);
            n++;
            if (n == 1) check("basic_clear_once", 32'(sng_clear), 32'd0);
        end
        check("basic_latency", 32'(n), 32'd4);
        check("basic_en_cycles", 32'(en_cycles), 32'd4);
        check("basic_result", 32'(result), 32'd32);
        check("basic_en_drop", 32'(sng_en), 32'd0);
        bit_valid = 1'b0;
        take_result();
        check("basic_idle_busy", 32'(busy), 32'd0);

        // Stalled beats: 1 + 2 + 3 ones, gaps carry all-ones data that must be ignored.
        start = 1'b1; len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bit_valid = 1'b1; bit_in = stall_beats[b];
            @(negedge clk);
            bit_valid = 1'b0; bit_in = 8'hFF;
            if (b < 2) begin
                @(negedge clk);
                check("stall_sng_en_gap", 32'(sng_en), 32'd1);
                @(negedge clk);
            end
        end
        check("stall_res_valid", 32'(res_valid), 32'd1);
        check("stall_result", 32'(result), 32'd6);
        take_result();

        // Abort mid-run keeps the previous result, then a fresh one-beat run.
        start = 1'b1; len = 16'd10; bit_valid = 1'b1; bit_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1; bit_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_result_held", 32'(result), 32'd6);
        repeat (3) @(negedge clk);
        start = 1'b1; len = 16'd1;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b1; bit_in = 8'hAA;
        @(negedge clk);
        bit_valid = 1'b0;
        check("restart_result", 32'(result), 32'd4);
        take_result();

        // Zero length with backpressure; start pulses in DONE are dropped.
        start = 1'b1; len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_res_valid", 32'(res_valid), 32'd1);
        check("zero_result", 32'(result), 32'd0);
        check("zero_no_clear", 32'(sng_clear), 32'd0);
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0); len = 16'd5;
            @(negedge clk);
        end
        start = 1'b0;
        check("zero_held_valid", 32'(res_valid), 32'd1);
        check("zero_held_result", 32'(result), 32'd0);
        take_result();
        check("zero_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("zero_no_run", 32'(sng_en), 32'd0);

        // Randomized traffic, checked by the model each cycle.
        for (int i = 0; i < 6000; i++) begin
            start     = ($urandom % 4) == 0;
            len       = LEN_W'($urandom_range(0, 12));
            abort     = ($urandom % 50) == 0;
            bit_valid = ($urandom % 3) != 0;
            bit_in    = NUM_BITS'($urandom);
            res_ready = ($urandom % 3) == 0;
            @(negedge clk);
        end
        start = 1'b0; bit_valid = 1'b0; res_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("rand_quiesce", 32'(busy), 32'd0);

        // Longest possible run, all ones.
        start = 1'b1; len = 16'hFFFF; bit_valid = 1'b1; bit_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_valid(70000, n);
        check("max_result", 32'(result), 32'd524280);
        bit_valid = 1'b0;
        take_result();

        // Second run interrupted by asynchronous reset between clock edges.
        start = 1'b1; len = 16'd100; bit_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_sng_en", 32'(sng_en), 32'd0);
        check("async_bit_ready", 32'(bit_ready), 32'd0);
        check("async_res_valid", 32'(res_valid), 32'd0);
        check("async_result", 32'(result), 32'd0);
        bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_res_valid", 32'(res_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sc_accum_sequencer.md
Name: sc_accum_sequencer

Overview:
- Sequences one stochastic-computing accumulation run over a programmed number of bitstream cycles.
- Each run clears and enables the stochastic number generators (SNGs) and accepts NUM_BITS parallel stream bits per valid beat.
- Accumulates the popcount of every accepted beat and publishes the final count over a valid/ready result handshake.
- Sits between the host/control logic and the SNG + bitstream datapath. It replaces free-running, unclocked counting with a clocked, length-bounded measurement.

Parameters:
- NUM_BITS, 8, number of parallel bitstream lanes sampled per beat.
- LEN_W, 16, width of the stream-length field.
- ACC_W, 20, width of the accumulator/result; must be ≥ LEN_W + ceil(log2(NUM_BITS+1)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a new run; sampled only in IDLE.
- len  in  LEN_W  stream length in beats; sampled with start.
- abort  in  1  cancel current run; highest priority.
- busy  out  1  high in RUN and DONE.
- sng_clear  out  1  one-cycle pulse to reseed SNGs at run start.
- sng_en  out  1  SNG enable; high only in RUN.
- bit_valid  in  1  stream beat valid.
- bit_in  in  NUM_BITS  stream bits for this beat.
- bit_ready  out  1  high only in RUN; a beat is accepted when bit_valid && bit_ready.
- result  out  ACC_W  total ones counted in the last completed run.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous) forces:
  - state IDLE;
  - busy, sng_clear, sng_en, bit_ready, res_valid = 0;
  - result = 0, internal acc = 0, remaining = 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start && !abort && len!=0 → RUN next cycle. Load remaining=len, acc=0, and assert sng_clear for exactly the first RUN cycle.
  - start && !abort && len==0 → DONE next cycle with result=0. No sng_clear, no sng_en.
  - start && abort → stay IDLE.
- RUN:
  - sng_en=1, bit_ready=1.
  - On an accepted beat: acc += popcount(bit_in), zero-extended to ACC_W; remaining decrements by 1.
  - Cycles with bit_valid=0 change nothing, and the run does not time out.
  - On an accepted beat with remaining==1: go to DONE next cycle, result = acc + popcount(bit_in), res_valid=1. sng_en and bit_ready drop in that same next cycle.
  - Latency: res_valid rises exactly 1 cycle after the len-th accepted beat.
- DONE:
  - res_valid=1; result stable.
  - res_ready=1 → IDLE next cycle with res_valid=0.
  - start is ignored in DONE and RUN; it is not queued.
- abort in RUN or DONE → IDLE next cycle. sng_en, bit_ready and res_valid go to 0; result keeps the previously published value and is not updated.
- result changes only on DONE entry or reset, and holds its value through IDLE.
- Accumulator never wraps given the ACC_W constraint. The maximum is (2^LEN_W − 1)·NUM_BITS.
- rst_n asserted mid-run discards all progress; no result is published.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0; release and idle 5 cycles → outputs stay 0, busy=0.
- Basic run: start, len=4, bit_in=8'hFF, bit_valid=1 continuously → sng_clear high in 1st RUN cycle only; sng_en high for 4 cycles; res_valid rises the cycle after the 4th beat; result=32; res_ready=1 → busy=0 next cycle.
- Stalls: len=3, beats 8'h01, 8'h03, 8'h07 with bit_valid=0 for 2 cycles between beats (bit_in=8'hFF during the gaps) → result=6; sng_en stays high through the gaps.
- Zero length and backpressure: start, len=0 → DONE next cycle, result=0. Hold res_ready=0 for 5 cycles while pulsing start with len=5 → result held at 0, start ignored. Raise res_ready → IDLE, and no RUN follows.
- Abort then restart: start, len=10, 2 beats of 8'hFF, then abort → IDLE next cycle, res_valid never rises, result still holds its prior value. Then start, len=1, beat 8'hAA → result=4.
- Maximum count: len=16'hFFFF, all beats 8'hFF → result=524280 with no overflow. Also assert rst_n low mid-run on a second run → all outputs 0 immediately, asynchronously.
